// File: rtl/coordinate_merger.sv
// coordinate_merger: joins skewed X/Y/Z axis streams into {W,Z,Y,X} 128-bit points; COORD_MERGE_SEQ_TAG_EN puts a sequence tag in W
module coordinate_merger #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] W_FILL = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         x_valid,
  input  logic [31:0]  x_data,
  output logic         x_ready,
  input  logic         y_valid,
  input  logic [31:0]  y_data,
  output logic         y_ready,
  input  logic         z_valid,
  input  logic [31:0]  z_data,
  output logic         z_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic [15:0]  merged_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] mem [3][FIFO_DEPTH];
  logic [AW:0] wp [3];
  logic [AW:0] rp [3];
  logic [31:0] din [3];
  logic [31:0] head [3];
  logic [2:0] vin, rdy, full, empty, push;
  logic alive, merge;
  logic [31:0] w;
  assign din[0] = x_data;
  assign din[1] = y_data;
  assign din[2] = z_data;
  assign vin = {z_valid, y_valid, x_valid};
  assign {z_ready, y_ready, x_ready} = rdy;
  for (genvar i = 0; i < 3; i++) begin : g_axis
    assign full[i] = (wp[i][AW] != rp[i][AW]) && (wp[i][AW-1:0] == rp[i][AW-1:0]);
    assign empty[i] = wp[i] == rp[i];
    assign head[i] = mem[i][rp[i][AW-1:0]];
    assign rdy[i] = alive && !full[i];
  end
  assign push = vin & rdy;
  assign merge = !(|empty) && (!out_valid || out_ready);
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (push[k]) mem[k][wp[k][AW-1:0]] <= din[k];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alive <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
    end else begin
      alive <= 1'b1;
      for (int k = 0; k < 3; k++) begin
        wp[k] <= wp[k] + {{AW{1'b0}}, push[k]};
        rp[k] <= rp[k] + {{AW{1'b0}}, merge};
      end
    end
`ifdef COORD_MERGE_SEQ_TAG_EN
  logic [31:0] tag;
  always_ff @(posedge clk or posedge rst)
    if (rst) tag <= '0;
    else if (merge) tag <= tag + 32'd1;
  assign w = tag;
`else
  assign w = W_FILL;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      merged_cnt <= '0;
    end else begin
      if (out_valid && out_ready) merged_cnt <= merged_cnt + 16'd1;
      if (merge) begin
        out_valid <= 1'b1;
        out_data <= {w, head[2], head[1], head[0]};
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_coordinate_merger.sv
// tb_coordinate_merger: directed and random stimulus against a queue-level reference model of the merger
module tb_coordinate_merger;
  localparam int D = 4;
  logic clk = 0, rst = 1;
  logic xv = 0, yv = 0, zv = 0, ordy = 0;
  logic [31:0] xd = 0, yd = 0, zd = 0;
  logic xr, yr, zr, ov;
  logic [127:0] od;
  logic [15:0] mc;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q0[$], q1[$], q2[$];
  logic m_alive, m_ov;
  logic [127:0] m_od;
  logic [15:0] m_cnt;
  logic [31:0] m_tag;

  coordinate_merger #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .x_valid(xv), .x_data(xd), .x_ready(xr),
    .y_valid(yv), .y_data(yd), .y_ready(yr),
    .z_valid(zv), .z_data(zd), .z_ready(zr),
    .out_valid(ov), .out_data(od), .out_ready(ordy),
    .merged_cnt(mc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wexp();
`ifdef COORD_MERGE_SEQ_TAG_EN
    return m_tag;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    m_alive = 0; m_ov = 0; m_od = '0; m_cnt = '0; m_tag = '0;
  endtask

  task automatic drive(input bit a, input logic [31:0] da, input bit b, input logic [31:0] db,
                       input bit c, input logic [31:0] dc, input bit r);
    xv = a; xd = da; yv = b; yd = db; zv = c; zd = dc; ordy = r;
  endtask

  // one clock: check readies before the edge, advance the model, check outputs after it
  task automatic step();
    bit r0, r1, r2, mg;
    logic [31:0] a, b, c;
    r0 = m_alive && q0.size() < D;
    r1 = m_alive && q1.size() < D;
    r2 = m_alive && q2.size() < D;
    mg = q0.size() > 0 && q1.size() > 0 && q2.size() > 0 && (!m_ov || ordy);
    chk("x_ready", xr, r0);
    chk("y_ready", yr, r1);
    chk("z_ready", zr, r2);
    @(posedge clk);
    if (m_ov && ordy) m_cnt++;
    if (mg) begin
      a = q0.pop_front(); b = q1.pop_front(); c = q2.pop_front();
      m_od = {wexp(), c, b, a};
      m_ov = 1;
      m_tag++;
    end else if (ordy) m_ov = 0;
    if (xv && r0) q0.push_back(xd);
    if (yv && r1) q1.push_back(yd);
    if (zv && r2) q2.push_back(zd);
    m_alive = 1;
    #1;
    chk("out_valid", ov, m_ov);
    chk("out_data", od, m_od);
    chk("merged_cnt", mc, m_cnt);
  endtask

  task automatic idle(input int n, input bit r);
    drive(0, 0, 0, 0, 0, 0, r);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k, start;
    bit acc;
    model_reset();
    #2;
    chk("rst_x_ready", xr, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_merged_cnt", mc, 0);
    @(posedge clk); #1;
    rst = 0;
    idle(1, 1);
    chk("ready_up", {zr, yr, xr}, 3'b111);

    // aligned single point
    drive(1, 32'h1, 1, 32'h2, 1, 32'h3, 1);
    step();
    chk("aligned_not_yet", ov, 0);
    idle(1, 1);
    chk("aligned_valid", ov, 1);
    chk("aligned_data", od, 128'h00000000_00000003_00000002_00000001);
    idle(1, 1);
    chk("aligned_cnt", mc, 16'd1);

    // skewed axes
    drive(1, 32'hAAAA_0001, 0, 0, 0, 0, 1); step();
    idle(2, 1);
    drive(0, 0, 1, 32'hBBBB_0002, 0, 0, 1); step();
    idle(1, 1);
    drive(0, 0, 0, 0, 1, 32'hCCCC_0003, 1); step();
    chk("skew_wait", ov, 0);
    idle(1, 1);
    chk("skew_valid", ov, 1);
    chk("skew_xyz", od[95:0], 96'hCCCC0003_BBBB0002_AAAA0001);
    idle(2, 1);

    // axis overrun stall
    for (int i = 0; i < D; i++) begin
      drive(1, 32'h100 + i, 0, 0, 0, 0, 1); step();
    end
    drive(1, 32'hDEAD, 0, 0, 0, 0, 1);
    chk("overrun_x_ready", xr, 0);
    step();
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 32'h200 + i, 1, 32'h300 + i, 1); step();
    end
    idle(3, 1);
    chk("overrun_last_x", od[31:0], 32'h103);
    chk("overrun_x_ready_back", xr, 1);

    // backpressure: out_ready pattern 1,0,0
    start = m_cnt;
    k = 0;
    for (int cyc = 0; cyc < 200 && (k < 10 || m_ov || q0.size() > 0); cyc++) begin
      acc = m_alive && q0.size() < D;
      drive(k < 10, 32'h400 + k, k < 10, 32'h500 + k, k < 10, 32'h600 + k, cyc % 3 == 0);
      step();
      if (acc && k < 10) k++;
    end
    chk("bp_cnt", mc, 16'(start + 10));

    // reset mid-stream with output held and 2 entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h700 + i, 1, 32'h800 + i, 1, 32'h900 + i, 0); step();
    end
    idle(1, 0);
    chk("pre_rst_valid", ov, 1);
    rst = 1;
    #1;
    model_reset();
    chk("mid_rst_valid", ov, 0);
    chk("mid_rst_cnt", mc, 0);
    chk("mid_rst_ready", {zr, yr, xr}, 3'b000);
    @(posedge clk); #1;
    rst = 0;
    idle(1, 1);
    drive(1, 32'h11, 1, 32'h22, 1, 32'h33, 1); step();
    idle(1, 1);
    chk("post_rst_point", od, 128'h00000000_00000033_00000022_00000011);
    idle(2, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0);
      step();
    end
    idle(8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
